// File: rtl/edge_pulse_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_pulse_gen_if : channel bus for edge_pulse_gen                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface edge_pulse_gen_if #(
  parameter int N = 4
);
  logic [N-1:0] sig;
  logic [1:0]   mode;
  logic [N-1:0] clr;
  logic [N-1:0] pulse;
  logic [N-1:0] stable;
  logic [N-1:0] pending;

  modport master (output sig, mode, clr, input pulse, stable, pending);
  modport slave  (input sig, mode, clr, output pulse, stable, pending);
endinterface
`default_nettype wire

// File: rtl/edge_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_pulse_gen : per-channel sync, debounce, edge detect, pulse out  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module edge_pulse_gen #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int PULSE_LEN       = 1
) (
  input  logic             clk,
  input  logic             reset,
  edge_pulse_gen_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);

  localparam logic [DW-1:0] C_DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] C_DB_ONE     = DW'(1);
  localparam logic [PW-1:0] C_PULSE_LOAD = PW'(PULSE_LEN);
  localparam logic [PW-1:0] C_PULSE_ONE  = PW'(1);

  localparam logic [1:0] C_MODE_RISE = 2'b00;
  localparam logic [1:0] C_MODE_FALL = 2'b01;
  localparam logic [1:0] C_MODE_BOTH = 2'b10;

  logic         w_rise_en;
  logic         w_fall_en;
  logic [N-1:0] w_pulse;
  logic [N-1:0] w_stable;
  logic [N-1:0] w_pending;

  assign w_rise_en = (bus.mode == C_MODE_RISE) || (bus.mode == C_MODE_BOTH);
  assign w_fall_en = (bus.mode == C_MODE_FALL) || (bus.mode == C_MODE_BOTH);

  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q;
    logic                   stable_d;
    logic [DW-1:0]          db_cnt_q;
    logic [DW-1:0]          db_cnt_d;
    logic [PW-1:0]          p_cnt_q;
    logic [PW-1:0]          p_cnt_d;
    logic                   pulse_q;
    logic                   pending_q;
    logic                   pending_d;
    logic                   w_s;
    logic                   w_change;
    logic                   w_event;

    assign w_s = sync_q[SYNC_STAGES-1];

    // Any agreeing cycle discards the partial count, so short glitches vanish.
    always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      w_change = 1'b0;
      if (w_s == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == C_DB_LAST) begin
        stable_d = w_s;
        db_cnt_d = '0;
        w_change = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + C_DB_ONE;
      end
    end

    assign w_event = w_change & (w_s ? w_rise_en : w_fall_en);

    // An event during an active pulse reloads the count, stretching it gap-free.
    always_comb begin
      p_cnt_d = p_cnt_q;
      if (w_event) begin
        p_cnt_d = C_PULSE_LOAD;
      end else if (p_cnt_q != '0) begin
        p_cnt_d = p_cnt_q - C_PULSE_ONE;
      end
    end

    assign pending_d = w_event | (pending_q & ~bus.clr[i]);

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q    <= '0;
        stable_q  <= 1'b0;
        db_cnt_q  <= '0;
        p_cnt_q   <= '0;
        pulse_q   <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.sig[i]};
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        p_cnt_q   <= p_cnt_d;
        pulse_q   <= (p_cnt_d != '0);
        pending_q <= pending_d;
      end
    end

    assign w_pulse[i]   = pulse_q;
    assign w_stable[i]  = stable_q;
    assign w_pending[i] = pending_q;
  end

  assign bus.pulse   = w_pulse;
  assign bus.stable  = w_stable;
  assign bus.pending = w_pending;

endmodule
`default_nettype wire

// File: doc/edge_pulse_gen.md
# edge_pulse_gen

Multi-channel, parametrised edge-to-pulse generator for asynchronous inputs such as buttons and switches. Each channel synchronises its input, debounces it, and detects rising, falling or both edges according to a global mode. It then emits a pulse of programmable length and latches a sticky pending flag that software can clear. It sits between board-level inputs and the control FSMs, and each channel can be used where a single-cycle rising-edge tick was used before.

## Interface
- `N`, default 4, number of independent channels (≥1)
- `SYNC_STAGES`, default 2, synchroniser flops per channel (≥2)
- `DEBOUNCE_CYCLES`, default 1, consecutive cycles of disagreement needed before the debounced level changes (≥1)
- `PULSE_LEN`, default 1, pulse width in clock cycles (≥1)

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `sig`  in  N  raw asynchronous inputs, one bit per channel
- `mode`  in  2  edge select for all channels: 00 rise, 01 fall, 10 both, 11 disabled
- `clr`  in  N  write-1-to-clear for `pending`, one bit per channel
- `pulse`  out  N  output pulse per channel
- `stable`  out  N  debounced level per channel
- `pending`  out  N  sticky event flag per channel

## Operation
- Reset values: all synchroniser flops, `stable`, debounce counters, pulse counters, `pulse` and `pending` are 0.
- Synchroniser: per-channel shift chain of `SYNC_STAGES` flops. `s[i]` is the output of the last flop.
- Debounce, per channel, evaluated every cycle:
  - If `s == stable`, the counter loads 0.
  - Else, if the counter equals `DEBOUNCE_CYCLES-1`, `stable` loads `s`, the counter loads 0, and a level change is flagged for this cycle.
  - Else, the counter increments.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It never wraps.
- Event: a level change qualified by `mode`.
  - 00: 0→1 only.
  - 01: 1→0 only.
  - 10: either direction.
  - 11: never.
  - `mode` is sampled in the cycle the level change occurs. No buffering or retroactive evaluation.
- Pulse generator, per channel:
  - A down-counter of width `$clog2(PULSE_LEN+1)` loads `PULSE_LEN` on an event.
  - Otherwise it decrements if nonzero.
  - `pulse` is registered and high exactly when the counter is nonzero after the update.
- Retrigger: an event while a pulse is active reloads the counter to `PULSE_LEN`, extending the pulse. There is no low gap.
- Pending:
  - An event sets the bit.
  - `clr` high clears it.
  - Simultaneous event and `clr` on the same channel: the set wins and the bit stays 1.
- Channels are fully independent. There are no shared counters.
- Mode change mid-pulse: in-flight pulses complete unaffected. With mode 11, `stable` still tracks the input and only events are suppressed.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight pulse ends immediately.
- An input held high through reset is treated as a 0→1 transition after reset release. This produces one rise event if `mode` permits it.

## Timing
- Latency: an input change that is stable before clock edge 1 appears on `stable` and `pulse` after edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
  - With defaults, this is edge 3.
- `pulse` width is exactly `PULSE_LEN` cycles for an isolated event.
- After a retrigger, `pulse` stays high for `PULSE_LEN` cycles after the last event.
- `pending` rises on the same edge as `pulse`.
- `clr` takes effect on the edge on which it is sampled.
- Glitch rejection: a synchronised excursion shorter than `DEBOUNCE_CYCLES` cycles produces no `stable` change and no event.
  - The debounce counter returns to 0 on the first agreeing cycle.
- Minimum spacing between consecutive events on one channel is `DEBOUNCE_CYCLES` cycles.
- All outputs are driven directly from flops, with no combinational path from inputs.

## Test plan
- Reset state: defaults, N=4. Hold `reset` 3 cycles with `sig`=0000 → all outputs 0000 during reset and afterwards.
- Rise mode with default parameters: `sig[0]` 0→1 before edge 1 → `stable[0]`=1 and `pulse[0]`=1 at edge 3 only, `pending[0]`=1. Then `clr[0]` pulse → `pending[0]`=0 on the next edge.
- Debounce: `DEBOUNCE_CYCLES`=4. A 3-cycle high glitch on `sig[1]` → no `stable`, `pulse` or `pending` change. A 4-cycle high → `stable[1]`=1 at edge 2+4=6.
- Both-edges mode with stretch: `mode`=10, `PULSE_LEN`=3. `sig[2]` rises and falls 10 cycles apart → two 3-cycle pulses, `stable[2]` 1 then 0. Repeat with `mode`=01 → only the fall produces a pulse.
- Retrigger and clear race: `PULSE_LEN`=5, mode 10. Two events on `sig[3]` spaced 2 cycles apart → `pulse[3]` high 7 contiguous cycles. Assert `clr[3]` in the second event cycle → `pending[3]` remains 1.
- Disable and mid-reset: mode 11 with an edge on `sig[0]` → `stable[0]` follows, `pulse` and `pending` stay 0. With mode 00 and a 5-cycle pulse active, assert `reset` → `pulse`=0 on the next edge.
